// File: rtl/outport_seg_scanner_if.sv
// Interface between the OUTPORT register side and the 7-segment scanner.
// The master side owns the OUTPORT value, its load strobe and the display enable.
// The slave side drives the segment and anode outputs and the frame status.
interface outport_seg_scanner_if #(
   parameter int NUM_DIGITS = 4
);
   logic [31:0]           outportData;
   logic                  outportLoad;
   logic                  enable;
   logic [6:0]            seg;
   logic [NUM_DIGITS-1:0] anode;
   logic [2:0]            digit_idx;
   logic                  frame_done;

   modport master (
      output outportData, outportLoad, enable,
      input  seg, anode, digit_idx, frame_done
   );

   modport slave (
      input  outportData, outportLoad, enable,
      output seg, anode, digit_idx, frame_done
   );
endinterface

// File: rtl/outport_seg_scanner.sv
// outport_seg_scanner: drives a time-multiplexed hex 7-segment bank from the OUTPORT register.
//
// Buffering: OUTPORT writes land in `pending`. `display` is only reloaded while the
// scanner is OFF or when the scan wraps from the last digit back to digit 0, so a
// frame always shows a single consistent value.
//
// Slot timing: each digit is lit for CLK_DIV cycles. Every digit is followed by
// GAP_CYCLES cycles with all anodes off, which avoids ghosting between digits.
//
// Output registers: all outputs are registered. Each output register is loaded from
// the *next* state, so the outputs always line up with the current state register.
//
// Optional macro LEADING_ZERO_BLANK_EN: digits above the most-significant nonzero
// nibble are blanked. Digit 0 is always decoded.
module outport_seg_scanner #(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_DIV    = 50000,
   parameter int GAP_CYCLES = 16,
   parameter bit ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   outport_seg_scanner_if.slave  bus
);

   // One counter is shared by the SHOW and GAP phases, so it is sized for the longer of the two.
   localparam int PW = $clog2((CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES);

   localparam logic [PW-1:0]         SHOW_LAST  = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0]         GAP_LAST   = PW'(GAP_CYCLES - 1);
   localparam logic [2:0]            LAST_DIGIT = 3'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ONE_HOT    = NUM_DIGITS'(1);
   localparam logic [6:0]            SEG_OFF    = {7{ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};

   typedef enum logic [1:0] {
      ST_OFF,
      ST_SHOW,
      ST_GAP
   } state_t;

   state_t                state_q, state_d;
   logic [31:0]           pending_q, pending_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [31:0]           display_q, display_d;
   logic [PW-1:0]         prescaler_q, prescaler_d;
   logic [2:0]            digit_idx_q, digit_idx_d;
   logic                  frame_done_q, frame_done_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;

   logic                  refresh;
   logic [3:0]            nibble;
   logic [6:0]            seg_on;
`ifdef LEADING_ZERO_BLANK_EN
   logic [2:0]            msd;
`endif

   // Hex to active-high segment pattern {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   // Next-state logic: scan sequencing, double-buffer transfer and registered output values.
   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      pend_valid_d = pend_valid_q;
      display_d    = display_q;
      prescaler_d  = prescaler_q;
      digit_idx_d  = digit_idx_q;
      frame_done_d = 1'b0;
      refresh      = (state_q == ST_OFF);
      seg_d        = SEG_OFF;
      anode_d      = AN_OFF;
      nibble       = 4'h0;
      seg_on       = 7'h00;
`ifdef LEADING_ZERO_BLANK_EN
      msd          = 3'd0;
`endif

      if (bus.outportLoad) begin
         pending_d    = bus.outportData;
         pend_valid_d = 1'b1;
      end

      if (!bus.enable) begin
         state_d     = ST_OFF;
         digit_idx_d = 3'd0;
         prescaler_d = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d     = ST_SHOW;
               digit_idx_d = 3'd0;
               prescaler_d = '0;
            end
            ST_SHOW: begin
               if (prescaler_q == SHOW_LAST) begin
                  state_d      = ST_GAP;
                  prescaler_d  = '0;
                  frame_done_d = (digit_idx_q == LAST_DIGIT);
               end else begin
                  prescaler_d = prescaler_q + PW'(1);
               end
            end
            ST_GAP: begin
               if (prescaler_q == GAP_LAST) begin
                  state_d     = ST_SHOW;
                  prescaler_d = '0;
                  if (digit_idx_q == LAST_DIGIT) begin
                     digit_idx_d = 3'd0;
                     refresh     = 1'b1;
                  end else begin
                     digit_idx_d = digit_idx_q + 3'd1;
                  end
               end else begin
                  prescaler_d = prescaler_q + PW'(1);
               end
            end
            default: begin
               state_d     = ST_OFF;
               digit_idx_d = 3'd0;
               prescaler_d = '0;
            end
         endcase
      end

      // A write arriving on the transfer cycle bypasses pending and goes straight to display.
      if (refresh) begin
         if (bus.outportLoad) begin
            display_d    = bus.outportData;
            pend_valid_d = 1'b0;
         end else if (pend_valid_q) begin
            display_d    = pending_q;
            pend_valid_d = 1'b0;
         end
      end

      nibble = display_d[{digit_idx_d, 2'b00} +: 4];
      seg_on = hex7(nibble);
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (display_d[4*i +: 4] != 4'h0) msd = 3'(i);
      end
      if (digit_idx_d > msd) seg_on = 7'h00;
`endif

      case (state_d)
         ST_SHOW: begin
            seg_d   = seg_on ^ SEG_OFF;
            anode_d = (ONE_HOT << digit_idx_d) ^ AN_OFF;
         end
         ST_GAP: begin
            seg_d   = seg_q;
            anode_d = AN_OFF;
         end
         default: begin
            seg_d   = SEG_OFF;
            anode_d = AN_OFF;
         end
      endcase
   end

   // State and output registers with synchronous reset to the blanked OFF condition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_OFF;
         pending_q    <= '0;
         pend_valid_q <= 1'b0;
         display_q    <= '0;
         prescaler_q  <= '0;
         digit_idx_q  <= 3'd0;
         frame_done_q <= 1'b0;
         seg_q        <= SEG_OFF;
         anode_q      <= AN_OFF;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         pend_valid_q <= pend_valid_d;
         display_q    <= display_d;
         prescaler_q  <= prescaler_d;
         digit_idx_q  <= digit_idx_d;
         frame_done_q <= frame_done_d;
         seg_q        <= seg_d;
         anode_q      <= anode_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.anode      = anode_q;
   assign bus.digit_idx  = digit_idx_q;
   assign bus.frame_done = frame_done_q;

endmodule
